// File: rtl/checker_pkg.sv
// Shared types and defaults for the result checker and the core it observes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_PASS = 3'd2,
        ST_FAIL = 3'd3,
        ST_TMO  = 3'd4
    } state_t;

    localparam int XLEN_DEF    = 32;
    localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/exp_table.sv
// Expected-value table: DEPTH x XLEN registers, one write port, asynchronous read.
// Latency: a write lands on the clock edge; the read port is combinational.
// Backpressure: none; every cycle with we high is written.
module exp_table #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/result_checker.sv
// Compares each valid core result, in order, against a loadable expected table.
// Latency: verdict appears on done/pass one cycle after the deciding result cycle.
// Backpressure: none; results are observed passively, never stalled.
module result_checker
    import checker_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            exp_we,
    input  logic [AW-1:0]   exp_addr,
    input  logic [XLEN-1:0] exp_data,
    input  logic [AW:0]     exp_count,
    input  logic [XLEN-1:0] result,
    input  logic            result_valid,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [AW-1:0]   fail_idx,
    output logic [XLEN-1:0] fail_value,
    output logic [CW-1:0]   cycle_count
);

    localparam int            TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   N_MAX    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   N_ONE    = (AW+1)'(1);

    state_t          state;
    logic [AW:0]     n;
    logic [AW-1:0]   idx;
    logic [TW-1:0]   tmo_cnt;
    logic [XLEN-1:0] exp_val;
    logic [AW:0]     n_start;
    logic            table_we;
    logic            match;
    logic            last;
    logic            tmo_hit;

    // The table is frozen while a run is reading it.
    assign table_we = exp_we && (state != ST_RUN);

    exp_table #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_exp_table (
        .clk   (clk),
        .we    (table_we),
        .waddr (exp_addr),
        .wdata (exp_data),
        .raddr (idx),
        .rdata (exp_val)
    );

    assign n_start = (exp_count > N_MAX) ? N_MAX : exp_count;
    assign match   = (result == exp_val);
    assign last    = ({1'b0, idx} == (n - N_ONE));
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            n           <= '0;
            idx         <= '0;
            tmo_cnt     <= '0;
            cycle_count <= '0;
            fail_idx    <= '0;
            fail_value  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CW'(1);
                    end
                    // A valid result always takes precedence over timeout expiry.
                    if (n == '0) begin
                        state <= ST_PASS;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (result_valid && match) begin
                        tmo_cnt <= '0;
                        if (last) begin
                            state <= ST_PASS;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end else if (result_valid) begin
                        state      <= ST_FAIL;
                        fail_idx   <= idx;
                        fail_value <= result;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else if (tmo_hit) begin
                        state   <= ST_TMO;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    if (start) begin
                        state       <= ST_RUN;
                        n           <= n_start;
                        idx         <= '0;
                        tmo_cnt     <= '0;
                        cycle_count <= '0;
                        fail_idx    <= '0;
                        fail_value  <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: directed vector table, hand-written corner sequences,
// then randomized runs scored against a run-level reference model.
module tb_result_checker;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TMO   = 8;
    localparam int CW    = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            exp_we;
    logic [AW-1:0]   exp_addr;
    logic [XLEN-1:0] exp_data;
    logic [AW:0]     exp_count;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic            busy;
    logic            done;
    logic            pass;
    logic            timeout;
    logic [AW-1:0]   fail_idx;
    logic [XLEN-1:0] fail_value;
    logic [CW-1:0]   cycle_count;

    always #5 clk = ~clk;

    result_checker #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .TIMEOUT (TMO),
        .CW      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .exp_we       (exp_we),
        .exp_addr     (exp_addr),
        .exp_data     (exp_data),
        .exp_count    (exp_count),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .fail_idx     (fail_idx),
        .fail_value   (fail_value),
        .cycle_count  (cycle_count)
    );

    int total  = 0;
    int passed = 0;

    logic [31:0] tbl_model [16];
    logic [31:0] drv_val   [16];
    int          drv_gap   [16];

    // kind: 0 = pass, 1 = mismatch, 2 = timeout
    typedef struct {
        string       name;
        int          n;
        int          nres;
        int          bad_at;
        logic [31:0] bad_val;
        int          gap_all;
        int          gap_at;
        int          gap_len;
        int          kind;
        int          fidx;
        logic [31:0] fval;
        int          cyc;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic write_tbl(input int addr, input logic [31:0] data);
        exp_we   = 1'b1;
        exp_addr = 4'(addr);
        exp_data = data;
        tick();
        exp_we   = 1'b0;
        tbl_model[addr] = data;
    endtask

    task automatic do_start(input int n_in);
        exp_count = 5'(n_in);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic drive_run(input int nres);
        for (int i = 0; i < nres; i++) begin
            for (int g = 0; g < drv_gap[i]; g++) tick();
            result_valid = 1'b1;
            result       = drv_val[i];
            tick();
            result_valid = 1'b0;
            result       = '0;
        end
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        check({nm, "_done_wait"}, 64'(done), 64'(1));
    endtask

    task automatic check_verdict(input string nm, input int kind, input int fidx,
                                 input logic [31:0] fval, input int cyc);
        check({nm, "_flags"}, 64'({busy, done, pass, timeout}),
              64'({1'b0, 1'b1, (kind == 0), (kind == 2)}));
        check({nm, "_fail_idx"}, 64'(fail_idx), 64'(fidx));
        check({nm, "_fail_value"}, 64'(fail_value), 64'(fval));
        check({nm, "_cycle_count"}, 64'(cycle_count), 64'(cyc));
    endtask

    // Run-level model: walk the planned results, charging each gap plus the valid cycle.
    function automatic void model(input int n_in, input int nres, output int kind,
                                  output int fidx, output logic [31:0] fval, output int cyc);
        int n;
        int c;
        n    = (n_in > DEPTH) ? DEPTH : n_in;
        c    = 0;
        kind = 2;
        fidx = 0;
        fval = '0;
        cyc  = 0;
        if (n == 0) begin
            kind = 0;
            cyc  = 1;
            return;
        end
        for (int i = 0; i < nres; i++) begin
            if (drv_gap[i] >= TMO) begin
                kind = 2;
                cyc  = c + TMO;
                return;
            end
            c += drv_gap[i] + 1;
            if (drv_val[i] != tbl_model[i]) begin
                kind = 1;
                fidx = i;
                fval = drv_val[i];
                cyc  = c;
                return;
            end
            if (i == n - 1) begin
                kind = 0;
                cyc  = c;
                return;
            end
        end
        kind = 2;
        cyc  = c + TMO;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{"pass3",     3,  3, -1, 32'h0,        0, -1, 0, 0, 0,  32'h0,        3};
        vecs[1]  = '{"fail_dead", 3,  3,  1, 32'hDEAD,     0, -1, 0, 1, 1,  32'hDEAD,     2};
        vecs[2]  = '{"tmo_idle",  3,  0, -1, 32'h0,        0, -1, 0, 2, 0,  32'h0,        8};
        vecs[3]  = '{"late8",     3,  3, -1, 32'h0,        0,  0, 7, 0, 0,  32'h0,        10};
        vecs[4]  = '{"tmo_mid",   3,  3, -1, 32'h0,        0,  1, 8, 2, 0,  32'h0,        9};
        vecs[5]  = '{"n0",        0,  2, -1, 32'h0,        0, -1, 0, 0, 0,  32'h0,        1};
        vecs[6]  = '{"clamp20",   20, 16, -1, 32'h0,       0, -1, 0, 0, 0,  32'h0,        16};
        vecs[7]  = '{"fail15",    16, 16, 15, 32'h0,       0, -1, 0, 1, 15, 32'h0,        16};
        vecs[8]  = '{"fail0",     1,  1,  0, 32'hFFFFFFFF, 0, -1, 0, 1, 0,  32'hFFFFFFFF, 1};
        vecs[9]  = '{"n1",        1,  1, -1, 32'h0,        0, -1, 0, 0, 0,  32'h0,        1};
        vecs[10] = '{"spaced",    4,  4, -1, 32'h0,        2, -1, 0, 0, 0,  32'h0,        12};

        rst = 1'b1; start = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
        exp_count = '0; result = '0; result_valid = 1'b0;
        tick(); tick(); tick();
        check("rst_flags", 64'({busy, done, pass, timeout}), 64'(0));
        check("rst_fail_idx", 64'(fail_idx), 64'(0));
        check("rst_fail_value", 64'(fail_value), 64'(0));
        check("rst_cycle_count", 64'(cycle_count), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) write_tbl(i, 32'(i + 1));

        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < DEPTH; i++) begin
                drv_val[i] = (i == vecs[v].bad_at) ? vecs[v].bad_val : 32'(i + 1);
                drv_gap[i] = vecs[v].gap_all + ((i == vecs[v].gap_at) ? vecs[v].gap_len : 0);
            end
            do_start(vecs[v].n);
            drive_run(vecs[v].nres);
            wait_done(vecs[v].name);
            check_verdict(vecs[v].name, vecs[v].kind, vecs[v].fidx, vecs[v].fval, vecs[v].cyc);
        end

        // Reset mid-run after one match, then rerun on the retained table.
        for (int i = 0; i < DEPTH; i++) begin
            drv_val[i] = 32'(i + 1);
            drv_gap[i] = 0;
        end
        do_start(3);
        drive_run(1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_flags", 64'({busy, done, pass, timeout}), 64'(0));
        check("midrst_fail_value", 64'(fail_value), 64'(0));
        check("midrst_cycle_count", 64'(cycle_count), 64'(0));
        do_start(3);
        drive_run(3);
        wait_done("after_rst");
        check_verdict("after_rst", 0, 0, 32'h0, 3);

        // Valid on the last allowed cycle restarts the timeout window.
        do_start(3);
        for (int g = 0; g < 7; g++) tick();
        result_valid = 1'b1; result = 32'h1;
        tick();
        result_valid = 1'b0; result = '0;
        check("late_valid_busy", 64'({busy, done}), 64'(2'b10));
        for (int g = 0; g < 7; g++) tick();
        check("window_reset_busy", 64'({busy, timeout}), 64'(2'b10));
        tick();
        check("window_reset_tmo", 64'({busy, timeout}), 64'(2'b01));
        check("window_reset_cycles", 64'(cycle_count), 64'(16));

        // Table write and start are both ignored while running.
        do_start(3);
        exp_we = 1'b1; exp_addr = '0; exp_data = 32'h55;
        tick();
        exp_we = 1'b0;
        result_valid = 1'b1; result = 32'h1; tick();
        result_valid = 1'b0; result = '0;
        exp_count = '0; start = 1'b1; tick(); start = 1'b0;
        result_valid = 1'b1; result = 32'h2; tick();
        result = 32'h3; tick();
        result_valid = 1'b0; result = '0;
        wait_done("run_we_start");
        check_verdict("run_we_start", 0, 0, 32'h0, 5);
        do_start(3);
        drive_run(3);
        wait_done("rerun_tbl0");
        check_verdict("rerun_tbl0", 0, 0, 32'h0, 3);

        // A write from a terminal state is visible to a start on the next cycle.
        write_tbl(0, 32'h77);
        drv_val[0] = 32'h77;
        do_start(1);
        drive_run(1);
        wait_done("wr_then_start");
        check_verdict("wr_then_start", 0, 0, 32'h0, 1);
        write_tbl(0, 32'h1);

        for (int r = 0; r < 30; r++) begin
            int n_in, nres, kind, fidx, cyc;
            logic [31:0] fval;
            if (r % 6 == 0) begin
                for (int i = 0; i < DEPTH; i++) write_tbl(i, $urandom);
            end
            n_in = $urandom_range(0, 20);
            nres = (n_in > DEPTH) ? DEPTH : n_in;
            if (nres == 0) nres = 2;
            for (int i = 0; i < nres; i++) begin
                drv_val[i] = ($urandom_range(0, 11) == 0) ? $urandom : tbl_model[i];
                drv_gap[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 9)
                                                         : $urandom_range(0, 2);
            end
            model(n_in, nres, kind, fidx, fval, cyc);
            do_start(n_in);
            drive_run(nres);
            wait_done($sformatf("rnd%0d", r));
            check_verdict($sformatf("rnd%0d", r), kind, fidx, fval, cyc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Self-checking result monitor for the RISC-V core simulation and FPGA bring-up flow; sits beside `core` and observes its `result` bus.
- Holds a loadable table of expected result values and compares each valid core result, in order, against that table.
- Reports pass, fail (with the failing index and value) or timeout, plus a run-length cycle count.
- Successor to the bare clock-only test fixture: parametrised in data width, table depth and timeout.

Parameters:
- XLEN, 32, width of the result and expected-value datapath.
- DEPTH, 16, number of expected-value entries; must be a power of two, at least 2.
- AW, $clog2(DEPTH), expected-table address width (derived).
- TIMEOUT, 1024, maximum cycles allowed between consecutive valid results (including start to first result); must be at least 2.
- CW, 32, width of cycle_count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a check run.
- exp_we  in  1  expected-table write enable.
- exp_addr  in  AW  expected-table write address.
- exp_data  in  XLEN  expected-table write data.
- exp_count  in  AW+1  number of entries to check, 0..DEPTH; sampled on the start cycle.
- result  in  XLEN  core result bus.
- result_valid  in  1  qualifies result for one cycle.
- busy  out  1  high while in RUN.
- done  out  1  high in PASS, FAIL or TMO.
- pass  out  1  high only in PASS.
- timeout  out  1  high only in TMO.
- fail_idx  out  AW  table index of the first mismatch.
- fail_value  out  XLEN  result value that mismatched.
- cycle_count  out  CW  cycles spent in RUN.

Behaviour:
- States: IDLE, RUN, PASS, FAIL, TMO. Reset enters IDLE.
- On rst, all outputs are 0, idx=0, and the timeout counter is 0. Table contents are not reset.
- Reset mid-run: rst always wins and returns the block to IDLE on the next edge.
- Table writes:
  - exp_we writes the table at exp_addr in IDLE, PASS, FAIL and TMO.
  - exp_we is ignored in RUN.
  - A write lands on the edge; a start in the following cycle sees the new data.
- Starting a run:
  - start in any non-RUN state latches n=exp_count, sets idx=0, clears the timeout counter, cycle_count, fail_idx and fail_value, and enters RUN on the next edge.
  - start while in RUN is ignored.
  - exp_count greater than DEPTH is clamped to DEPTH.
- RUN, evaluated each cycle in this priority order:
  1. If n==0, go to PASS immediately (one cycle in RUN).
  2. If result_valid and result==table[idx]: idx increments and the timeout counter clears. If idx==n-1, go to PASS.
  3. If result_valid and result!=table[idx]: capture fail_idx=idx and fail_value=result, then go to FAIL.
  4. Otherwise the timeout counter increments. When it reaches TIMEOUT-1 with no valid that cycle, go to TMO.
  - A valid result in the same cycle as timeout expiry wins; it is compared and no timeout occurs.
- Latency: the verdict is visible on done/pass one cycle after the deciding result_valid cycle.
- Table read is combinational or from a register array (no read latency); comparison happens in the same cycle.
- cycle_count:
  - Increments every cycle in RUN, saturating at all-ones.
  - Holds its value in terminal states and clears only on start or rst.
- Terminal states hold all outputs until start or rst.
- result_valid outside RUN is ignored.
- All comparisons are full XLEN-bit equality. Counters are unsigned; idx wrap cannot occur because PASS is reached at n-1.

Decomposition:
- Shared package `checker_pkg` holds:
  - the state enum (IDLE=0, RUN=1, PASS=2, FAIL=3, TMO=4, 3-bit encoding);
  - default XLEN and TIMEOUT constants, shared with `core`.
- One natural sub-module, `exp_table`: the DEPTH×XLEN single-write-port, asynchronous-read register array.
- The FSM, timeout counter and cycle counter stay in result_checker.

Test Plan:
- Load table [0x1,0x2,0x3], exp_count=3, start, then valid results 0x1,0x2,0x3 on consecutive cycles -> pass=1 and done=1 one cycle after the third valid, cycle_count=3.
- Same table, valid results 0x1,0xDEAD -> FAIL with fail_idx=1, fail_value=0xDEAD, pass=0; a later valid 0x3 leaves the outputs unchanged.
- TIMEOUT=8, start with no valid results -> timeout=1 after 8 RUN cycles; a variant that gives valid 0x1 on the 8th cycle instead -> still RUN, counter cleared.
- exp_count=0, start -> PASS after exactly one RUN cycle.
- Assert rst mid-run after one matched result -> IDLE with all outputs 0; start again without reloading -> the table is retained and the run passes.
- exp_we to addr 0 during RUN -> ignored (table[0] unchanged, verified by a rerun); start during RUN -> ignored, idx unchanged.
